// File: rtl/mide_cpu_interp_if.sv
// mide_cpu_interp_if: start/select control and GPU-side VRAM read port
interface mide_cpu_interp_if;
  logic start_button;
  logic image_select;
  logic [31:0] gpu_address;
  logic [7:0] vram_out;
  modport master(output start_button, image_select, gpu_address, input vram_out);
  modport slave(input start_button, image_select, gpu_address, output vram_out);
endinterface

// File: rtl/mide_cpu_interp.sv
// mide_cpu_interp: 3x bilinear upscaler from ROM source images into a combinationally-read VRAM
module mide_cpu_interp #(
  parameter int SRC_W = 100,
  parameter int SRC_H = 100,
  parameter string IMG0_FILE = "img0.hex",
  parameter string IMG1_FILE = "img1.hex"
) (
  input logic clk,
  input logic gpu_clk,
  input logic reset,
  mide_cpu_interp_if.slave bus
);
  localparam int OUT_W = 3 * SRC_W;
  localparam int OUT_H = 3 * SRC_H;
  localparam int NPIX = OUT_W * OUT_H;
  localparam int AW = $clog2(SRC_W * SRC_H);
  localparam int KW = $clog2(NPIX);
  localparam int YW = $clog2(SRC_H + 1);
  localparam int XW = $clog2(SRC_W + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [7:0] rom0 [SRC_W*SRC_H];
  logic [7:0] rom1 [SRC_W*SRC_H];
  logic [7:0] vram [NPIX];
  logic prev, sel, go, last, row_end;
  logic [KW-1:0] k;
  logic [2:0] ph;
  logic [YW-1:0] sr, sr1;
  logic [XW-1:0] sc, sc1;
  logic [1:0] fr, fc;
  logic [AW-1:0] ra;
  logic [7:0] rd, a, b, c, d, top, bot, pix;
  logic unused_gpu;
  assign unused_gpu = gpu_clk;
  // (x*683)>>11 equals floor(x/3) over the whole 0..765 range a weighted sum can reach
  function automatic logic [7:0] div3(input logic [9:0] x);
    logic [19:0] p;
    p = 20'(x) * 20'd683;
    return 8'(p >> 11);
  endfunction
  function automatic logic [9:0] mix(input logic [7:0] x, input logic [7:0] y, input logic [1:0] f);
    return 10'(x) * 10'(2'd3 - f) + 10'(y) * 10'(f);
  endfunction
  always_comb begin
    go = bus.start_button && !prev;
    last = (k == KW'(NPIX - 1)) && (ph == 3'd5);
    row_end = (sc == XW'(SRC_W - 1)) && (fc == 2'd2);
    sr1 = (sr == YW'(SRC_H - 1)) ? sr : sr + 1'b1;
    sc1 = (sc == XW'(SRC_W - 1)) ? sc : sc + 1'b1;
    // phase bit 1 picks the lower neighbour row, bit 0 the right neighbour column
    ra = AW'(32'(ph[1] ? sr1 : sr) * SRC_W + 32'(ph[0] ? sc1 : sc));
    top = div3(mix(a, b, fc));
    bot = div3(mix(c, d, fc));
    pix = div3(mix(top, bot, fr));
    state_n = (state == IDLE && go) ? RUN :
              (state == RUN && last) ? DONE :
              (state == DONE) ? IDLE : state;
  end
  always_ff @(posedge clk) state <= reset ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (reset) begin
      prev <= 1'b0;
      sel <= 1'b0;
      k <= '0;
      ph <= '0;
      sr <= '0;
      sc <= '0;
      fr <= '0;
      fc <= '0;
    end else begin
      prev <= bus.start_button;
      if (state == IDLE && go) begin
        sel <= bus.image_select;
        k <= '0;
        ph <= '0;
        sr <= '0;
        sc <= '0;
        fr <= '0;
        fc <= '0;
      end else if (state == RUN) begin
        ph <= (ph == 3'd5) ? '0 : ph + 1'b1;
        if (ph == 3'd5) begin
          k <= k + 1'b1;
          fc <= (fc == 2'd2) ? '0 : fc + 1'b1;
          sc <= row_end ? '0 : (fc == 2'd2) ? sc + 1'b1 : sc;
          if (row_end) begin
            fr <= (fr == 2'd2) ? '0 : fr + 1'b1;
            sr <= (fr == 2'd2) ? sr + 1'b1 : sr;
          end
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    rd <= sel ? rom1[ra] : rom0[ra];
    if (ph == 3'd1) a <= rd;
    if (ph == 3'd2) b <= rd;
    if (ph == 3'd3) c <= rd;
    if (ph == 3'd4) d <= rd;
  end
  always_ff @(posedge clk)
    if (!reset && state == RUN && ph == 3'd5) vram[k] <= pix;
  assign bus.vram_out = (bus.gpu_address < 32'(NPIX)) ? vram[bus.gpu_address[KW-1:0]] : '0;
endmodule

// File: tb/tb_mide_cpu_interp.sv
// tb_mide_cpu_interp: random and directed frames checked against a floor-division bilinear model
module tb_mide_cpu_interp;
  localparam int W = 7;
  localparam int H = 5;
  localparam int OW = 3 * W;
  localparam int OH = 3 * H;
  localparam int NP = OW * OH;
  logic clk = 1'b0;
  logic gpu_clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  logic [7:0] img [2][W*H];
  int expv [NP];
  mide_cpu_interp_if bus();
  mide_cpu_interp #(.SRC_W(W), .SRC_H(H), .IMG0_FILE(""), .IMG1_FILE("")) dut (
    .clk(clk), .gpu_clk(gpu_clk), .reset(reset), .bus(bus)
  );
  always #5 clk = ~clk;
  always #7 gpu_clk = ~gpu_clk;
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic rand_img(input int im);
    for (int i = 0; i < W * H; i++) img[im][i] = 8'($urandom);
  endtask
  task automatic load(input int im);
    for (int i = 0; i < W * H; i++)
      if (im == 0) dut.rom0[i] = img[0][i];
      else dut.rom1[i] = img[1][i];
  endtask
  function automatic int px(input int im, input int y, input int x);
    return int'(img[im][(y > H - 1 ? H - 1 : y) * W + (x > W - 1 ? W - 1 : x)]);
  endfunction
  task automatic build_exp(input int im);
    for (int r = 0; r < OH; r++)
      for (int c = 0; c < OW; c++) begin
        int sr, fr, sc, fc, t, bt;
        sr = r / 3; fr = r % 3; sc = c / 3; fc = c % 3;
        t = (px(im, sr, sc) * (3 - fc) + px(im, sr, sc + 1) * fc) / 3;
        bt = (px(im, sr + 1, sc) * (3 - fc) + px(im, sr + 1, sc + 1) * fc) / 3;
        expv[r * OW + c] = (t * (3 - fr) + bt * fr) / 3;
      end
  endtask
  task automatic rd(input string tag, input int addr, input int exp);
    bus.gpu_address = 32'(addr);
    #1;
    check(tag, int'(bus.vram_out), exp);
  endtask
  task automatic cmp_frame(input string tag);
    for (int i = 0; i < NP; i++) rd($sformatf("%s[%0d]", tag, i), i, expv[i]);
  endtask
  task automatic run_frame(input logic s);
    @(negedge clk);
    bus.start_button = 1'b0;
    bus.image_select = s;
    @(negedge clk);
    bus.start_button = 1'b1;
    repeat (20) @(negedge clk);
    bus.image_select = ~s;
    repeat (6 * NP) @(negedge clk);
  endtask
  initial begin
    bus.start_button = 1'b0;
    bus.image_select = 1'b0;
    bus.gpu_address = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_k", int'(dut.k), 0);
    check("rst_sel", int'(dut.sel), 0);
    rd("oob_np", NP, 0);
    rd("oob_max", 32'hFFFF_FFFF, 0);
    rand_img(0);
    img[0][0] = 8'd30;
    img[0][1] = 8'd90;
    for (int r = 0; r < H; r++) img[0][r * W + W - 1] = 8'd200;
    rand_img(1);
    load(0);
    load(1);
    run_frame(1'b0);
    build_exp(0);
    rd("horiz0", 0, 30);
    rd("horiz1", 1, 50);
    rd("horiz2", 2, 70);
    rd("rclamp", OW - 1, 200);
    cmp_frame("f1");
    for (int i = 0; i < W * H; i++) img[0][i] = ~img[0][i];
    load(0);
    repeat (6 * NP + 10) @(negedge clk);
    cmp_frame("hold");
    rand_img(1);
    img[1][0] = 8'd0;
    img[1][1] = 8'd3;
    img[1][W] = 8'd6;
    img[1][W + 1] = 8'd9;
    load(1);
    run_frame(1'b1);
    rd("diag", OW + 1, 3);
    build_exp(1);
    cmp_frame("sel1");
    rand_img(0);
    img[0][0] = 8'd0;
    img[0][W] = 8'd255;
    load(0);
    run_frame(1'b0);
    rd("vert1", OW, 85);
    rd("vert2", 2 * OW, 170);
    build_exp(0);
    cmp_frame("f3");
    for (int i = 0; i < W * H; i++) img[0][i] = 8'h7B;
    load(0);
    run_frame(1'b0);
    for (int i = 0; i < NP; i++) rd($sformatf("const[%0d]", i), i, 8'h7B);
    rand_img(1);
    load(1);
    @(negedge clk);
    bus.start_button = 1'b0;
    bus.image_select = 1'b1;
    @(negedge clk);
    bus.start_button = 1'b1;
    repeat (300) @(negedge clk);
    reset = 1'b1;
    bus.start_button = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check("mid_k", int'(dut.k), 0);
    repeat (20) @(negedge clk);
    build_exp(1);
    for (int i = 49; i < NP; i++) expv[i] = 8'h7B;
    cmp_frame("abort");
    run_frame(1'b1);
    build_exp(1);
    cmp_frame("rerun");
    rd("oob_end", NP, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
